// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with hardware clear.
package regfile_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Widest word the byte-merge helper handles; callers zero-extend into it.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   // Replace each byte of old_word whose enable is set with the matching byte of new_word.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] result;
      result = old_word;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) begin
            result[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry to zero after reset or on request, and
// decides whether a user write is accepted or dropped.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int adder_width = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   we,
   output logic                   busy,
   output logic                   w_err,
   output logic                   clr_we,
   output logic [adder_width-1:0] clr_addr,
   output logic                   wr_accept
);

   state_t                 state;
   logic [adder_width-1:0] clr_ptr;

   // Sweep state, pointer, busy flag and the dropped-write pulse, all registered together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         busy    <= 1'b1;
         w_err   <= 1'b0;
      end else begin
         w_err <= we && ((state == CLEAR) || clr);
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + adder_width'(1);
               if (clr_ptr == '1) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               if (clr) begin
                  state   <= CLEAR;
                  clr_ptr <= '0;
                  busy    <= 1'b1;
               end
            end
         endcase
      end
   end

   assign clr_we    = (state == CLEAR) && !rst;
   assign clr_addr  = clr_ptr;
   assign wr_accept = (state == IDLE) && we && !clr && !rst;

endmodule

// File: rtl/multiport_regfile_clr.sv
// Register file with NUM_RD read ports, one byte-enabled write port, optional
// registered reads with write-first bypass, and a hardware clear sweep.
module multiport_regfile_clr
   import regfile_pkg::*;
#(
   parameter int data_width  = 16,
   parameter int adder_width = 3,
   parameter int NUM_RD      = 3,
   parameter int READ_REG    = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   output logic                          busy,
   input  logic                          we,
   input  logic [adder_width-1:0]        w_adder,
   input  logic [data_width-1:0]         w_data,
   input  logic [data_width/8-1:0]       w_be,
   output logic                          w_err,
   input  logic [NUM_RD*adder_width-1:0] r_adder,
   output logic [NUM_RD*data_width-1:0]  r_data
);

   localparam int DEPTH = 2 ** adder_width;

   if (data_width % 8 != 0) begin : g_bad_width
      $fatal(1, "data_width must be a multiple of 8");
   end
   if (data_width > MAX_DATA_W) begin : g_too_wide
      $fatal(1, "data_width exceeds the byte-merge helper width");
   end
   if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_ports
      $fatal(1, "NUM_RD must be in 1..8");
   end

   logic                   clr_we;
   logic [adder_width-1:0] clr_addr;
   logic                   wr_accept;
   logic [data_width-1:0]  wr_merged;
   logic [data_width-1:0]  mem [DEPTH];

   regfile_clr_seq #(
      .adder_width(adder_width)
   ) u_seq (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .we       (we),
      .busy     (busy),
      .w_err    (w_err),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .wr_accept(wr_accept)
   );

   // New word for the write address: stored word with the enabled bytes replaced.
   always_comb begin
      wr_merged = data_width'(byte_merge(MAX_DATA_W'(mem[w_adder]),
                                         MAX_DATA_W'(w_data),
                                         MAX_BE_W'(w_be)));
   end

   // Storage update: the clear sweep has priority, user writes only when accepted.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr_accept) begin
         mem[w_adder] <= wr_merged;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [adder_width-1:0] ra;
      assign ra = r_adder[k*adder_width +: adder_width];

      if (READ_REG == 0) begin : g_comb
         assign r_data[k*data_width +: data_width] = busy ? '0 : mem[ra];
      end else begin : g_reg
         logic [data_width-1:0] rd_q;

         // Registered read; a same-cycle accepted write to this address is forwarded.
         always_ff @(posedge clk) begin
            if (rst || busy) begin
               rd_q <= '0;
            end else if (wr_accept && (w_adder == ra)) begin
               rd_q <= wr_merged;
            end else begin
               rd_q <= mem[ra];
            end
         end

         assign r_data[k*data_width +: data_width] = rd_q;
      end
   end

endmodule

// File: tb/tb_multiport_regfile_clr.sv
// Self-checking bench: one combinational-read and one registered-read instance
// share stimulus and are compared against an array-level reference model.
module tb_multiport_regfile_clr;

   localparam int DW    = 16;
   localparam int AW    = 3;
   localparam int NR    = 3;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 2 ** AW;

   logic clk = 1'b0;
   logic rst, clr, we;
   logic [AW-1:0]    w_adder;
   logic [DW-1:0]    w_data;
   logic [BW-1:0]    w_be;
   logic [NR*AW-1:0] r_adder;
   logic             busy_c, werr_c, busy_r, werr_r;
   logic [NR*DW-1:0] rdata_c, rdata_r;

   // Free-running clock.
   always #5 clk = ~clk;

   multiport_regfile_clr #(
      .data_width(DW), .adder_width(AW), .NUM_RD(NR), .READ_REG(0)
   ) dut_comb (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy_c), .we(we),
      .w_adder(w_adder), .w_data(w_data), .w_be(w_be), .w_err(werr_c),
      .r_adder(r_adder), .r_data(rdata_c)
   );

   multiport_regfile_clr #(
      .data_width(DW), .adder_width(AW), .NUM_RD(NR), .READ_REG(1)
   ) dut_reg (
      .clk(clk), .rst(rst), .clr(clr), .busy(busy_r), .we(we),
      .w_adder(w_adder), .w_data(w_data), .w_be(w_be), .w_err(werr_r),
      .r_adder(r_adder), .r_data(rdata_r)
   );

   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_rreg [NR];
   logic          m_werr;
   int            busy_left;
   bit            model_valid;
   int            check_count;
   int            error_count;
   int            n_busy;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
      end
   endtask

   function automatic logic [DW-1:0] model_merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                                 input logic [BW-1:0] be);
      logic [DW-1:0] mask;
      mask = '0;
      for (int b = 0; b < BW; b++) begin
         if (be[b]) mask = mask | (DW'(8'hFF) << (8 * b));
      end
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   // Drive one cycle, check combinational reads before the edge and
   // registered outputs just after it.
   task automatic applyStimulus(input logic s_rst, input logic s_clr, input logic s_we,
                                input logic [AW-1:0] s_wa, input logic [DW-1:0] s_wd,
                                input logic [BW-1:0] s_be, input logic [AW-1:0] s_ra0,
                                input logic [AW-1:0] s_ra1, input logic [AW-1:0] s_ra2);
      logic [AW-1:0] ra [NR];
      ra[0] = s_ra0; ra[1] = s_ra1; ra[2] = s_ra2;
      rst = s_rst; clr = s_clr; we = s_we;
      w_adder = s_wa; w_data = s_wd; w_be = s_be;
      r_adder = {s_ra2, s_ra1, s_ra0};
      #1;
      if (model_valid) begin
         for (int k = 0; k < NR; k++) begin
            checkOutput($sformatf("comb_rd%0d", k), rdata_c[k*DW +: DW],
                        (busy_left > 0) ? '0 : m_mem[ra[k]]);
         end
      end
      if (s_rst) begin
         busy_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         m_werr = 1'b0;
         for (int k = 0; k < NR; k++) m_rreg[k] = '0;
      end else if (busy_left > 0) begin
         m_werr = s_we;
         for (int k = 0; k < NR; k++) m_rreg[k] = '0;
         busy_left--;
      end else begin
         for (int k = 0; k < NR; k++) begin
            if (s_we && !s_clr && s_wa == ra[k]) m_rreg[k] = model_merge(m_mem[ra[k]], s_wd, s_be);
            else                                  m_rreg[k] = m_mem[ra[k]];
         end
         m_werr = s_we && s_clr;
         if (s_clr) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
         end else if (s_we) begin
            m_mem[s_wa] = model_merge(m_mem[s_wa], s_wd, s_be);
         end
      end
      if (s_rst) model_valid = 1'b1;
      @(posedge clk);
      #1;
      if (model_valid) begin
         checkOutput("busy_c", busy_c, busy_left > 0);
         checkOutput("busy_r", busy_r, busy_left > 0);
         checkOutput("werr_c", werr_c, m_werr);
         checkOutput("werr_r", werr_r, m_werr);
         for (int k = 0; k < NR; k++) begin
            checkOutput($sformatf("reg_rd%0d", k), rdata_r[k*DW +: DW], m_rreg[k]);
         end
      end
   endtask

   task automatic idleCycle(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, a0, a1, a2);
   endtask

   initial begin
      check_count = 0;
      error_count = 0;
      model_valid = 1'b0;
      busy_left   = 0;

      // Reset for two cycles, then count busy cycles.
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 3'd0, 3'd3, 3'd7);
      applyStimulus(1'b1, 1'b0, 1'b1, 3'd2, 16'hFFFF, 2'b11, 3'd0, 3'd3, 3'd7);
      n_busy = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy_c) n_busy++;
         idleCycle(3'd0, 3'd3, 3'd7);
      end
      checkOutput("t1_busy_len", n_busy, 8);
      checkOutput("t1_rd_zero", rdata_c, '0);

      // Full-word write, then a low-byte-only write.
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 16'hA5C3, 2'b11, 3'd5, 3'd5, 3'd5);
      checkOutput("t2_rd_all", rdata_c, {3{16'hA5C3}});
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd5, 16'h1234, 2'b01, 3'd5, 3'd5, 3'd5);
      checkOutput("t3_rd0", rdata_c[15:0], 16'hA534);
      checkOutput("t3_rd2", rdata_c[47:32], 16'hA534);

      // Registered read bypass.
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd2, 16'hBEEF, 2'b11, 3'd2, 3'd3, 3'd5);
      checkOutput("t4_rd0", rdata_r[15:0], 16'hBEEF);
      checkOutput("t4_rd1", rdata_r[31:16], 16'h0000);
      checkOutput("t4_rd2", rdata_r[47:32], 16'hA534);

      // Clear request, then a write during the sweep.
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, 3'd1, 3'd2, 3'd5);
      n_busy = 0;
      if (busy_c) n_busy++;
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd1, 16'h5555, 2'b11, 3'd1, 3'd2, 3'd5);
      checkOutput("t5_werr_pulse", werr_c, 1'b1);
      if (busy_c) n_busy++;
      idleCycle(3'd1, 3'd2, 3'd5);
      checkOutput("t5_werr_clear", werr_c, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (busy_c) n_busy++;
         idleCycle(3'd1, 3'd2, 3'd5);
      end
      checkOutput("t5_busy_len", n_busy, 8);
      checkOutput("t5_addr1", rdata_c[15:0], 16'h0000);

      // Clear and write together, plus an ignored clear mid-sweep.
      applyStimulus(1'b0, 1'b0, 1'b1, 3'd4, 16'h1111, 2'b11, 3'd4, 3'd4, 3'd4);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 16'h7777, 2'b11, 3'd4, 3'd4, 3'd4);
      checkOutput("t6_werr", werr_c, 1'b1);
      n_busy = 0;
      for (int i = 0; i < 3; i++) begin
         if (busy_c) n_busy++;
         idleCycle(3'd4, 3'd4, 3'd4);
      end
      if (busy_c) n_busy++;
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, 3'd4, 3'd4, 3'd4);
      for (int i = 0; i < 10; i++) begin
         if (busy_c) n_busy++;
         idleCycle(3'd4, 3'd4, 3'd4);
      end
      checkOutput("t6_busy_len", n_busy, 8);
      checkOutput("t6_addr4", rdata_c[15:0], 16'h0000);

      // Randomised traffic with occasional clears and resets.
      for (int i = 0; i < 500; i++) begin
         applyStimulus($urandom_range(0, 99) == 0,
                       $urandom_range(0, 19) == 0,
                       1'($urandom_range(0, 1)),
                       AW'($urandom), DW'($urandom), BW'($urandom),
                       AW'($urandom), AW'($urandom), AW'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule
